// File: rtl/spi_rtl_pkg.sv
// Shared types for the SPI master serial engine.
//   spi_mst_state_e : engine FSM states
//   spi_mode_e      : SPI mode encoded as {cpol, cpha}
//   SPI_DATA_WIDTH_MIN/MAX : legal word-size bounds
package spi_rtl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT
  } spi_mst_state_e;

  typedef enum logic [1:0] {
    MODE0,
    MODE1,
    MODE2,
    MODE3
  } spi_mode_e;

  localparam int SPI_DATA_WIDTH_MIN = 4;
  localparam int SPI_DATA_WIDTH_MAX = 32;

  function automatic spi_mode_e mode_of(input logic cpol, input logic cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

endpackage

// File: rtl/spi_master_shifter_if.sv
// Word/handshake bus plus SPI pins of the serial engine.
//   slave  : engine side (accepts words, drives cs/sclk/mosi0, returns rx words)
//   master : host/bench side (offers words and config, drives miso0)
interface spi_master_shifter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  cpol;
  logic                  cpha;
  logic                  msb_first;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  busy;
  logic                  cs;
  logic                  sclk;
  logic                  mosi0;
  logic                  miso0;

  modport slave (
    input  tx_valid, tx_data, cpol, cpha, msb_first, miso0,
    output tx_ready, rx_valid, rx_data, busy, cs, sclk, mosi0
  );

  modport master (
    output tx_valid, tx_data, cpol, cpha, msb_first, miso0,
    input  tx_ready, rx_valid, rx_data, busy, cs, sclk, mosi0
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: divider, half-period counter and edge strobes.
//   pclk, areset : clock, synchronous active-high reset
//   cpol         : latched clock polarity (idle level of sclk)
//   in_lead      : FSM is in LEAD
//   in_shift     : FSM is in SHIFT
//   sclk         : serial clock
//   lead_edge    : this pclk edge toggles sclk away from cpol
//   trail_edge   : this pclk edge toggles sclk back to cpol
//   last_trail   : trail_edge that is the final sclk edge of the word
//   done         : last half-period elapses on this pclk edge
module spi_sclk_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic pclk,
  input  logic areset,
  input  logic cpol,
  input  logic in_lead,
  input  logic in_shift,
  output logic sclk,
  output logic lead_edge,
  output logic trail_edge,
  output logic last_trail,
  output logic done
);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGES  = 2 * DATA_WIDTH;
  localparam int EDGE_W = $clog2(EDGES);

  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;   // index of the SHIFT half-period in progress
  logic              phase;      // sclk is away from cpol
  logic              tick;

  assign tick = (in_lead || in_shift) && (div_cnt == DIV_W'(CLK_DIV - 1));

  // The LEAD wrap starts half-period 0 with the first (leading) edge; a SHIFT
  // wrap starts the next half-period, except after the final one.
  assign lead_edge  = tick && (in_lead ||
                      (in_shift && edge_cnt[0] && edge_cnt != EDGE_W'(EDGES - 1)));
  assign trail_edge = tick && in_shift && !edge_cnt[0];
  assign last_trail = trail_edge && (edge_cnt == EDGE_W'(EDGES - 2));
  assign done       = tick && in_shift && (edge_cnt == EDGE_W'(EDGES - 1));

  // Expressing sclk relative to the latched cpol makes a polarity change
  // appear at T+1 without counting as an edge.
  assign sclk = cpol ^ phase;

  always_ff @(posedge pclk) begin
    if (areset) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      phase    <= 1'b0;
    end else begin
      if (in_lead || in_shift) div_cnt <= tick ? '0 : div_cnt + 1'b1;
      else                     div_cnt <= '0;

      if (!in_shift) edge_cnt <= '0;
      else if (tick) edge_cnt <= done ? '0 : edge_cnt + 1'b1;

      if (lead_edge || trail_edge) phase <= ~phase;
    end
  end
endmodule

// File: rtl/spi_master_shifter.sv
// SPI master serial engine: one parallel word per transfer via valid/ready,
// serialized on mosi0 and deserialized from miso0 in the latched mode.
//   pclk, areset : clock, synchronous active-high reset
//   bus          : word handshake, config, rx return and SPI pins
//
// state | meaning
// IDLE  | cs high, tx_ready high, waiting for tx_valid
// LEAD  | cs low, sclk at cpol, one CLK_DIV setup before the first edge
// SHIFT | 2*DATA_WIDTH half-periods of sclk, shifting both directions
module spi_master_shifter
  import spi_rtl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input logic                pclk,
  input logic                areset,
  spi_master_shifter_if.slave bus
);
  spi_mst_state_e state_q, state_d;
  spi_mode_e      mode_q;
  logic           msb_q;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rx_data_q;
  logic           mosi_q, rx_valid_q;
  logic           accept, advance, sample;
  logic           sclk_int, lead_edge, trail_edge, last_trail, done;

  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w, input logic msb);
    return msb ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w,
                                                       input logic msb);
    return msb ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  spi_sclk_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .CLK_DIV   (CLK_DIV)
  ) u_sclk_gen (
    .pclk      (pclk),
    .areset    (areset),
    .cpol      (mode_q[1]),
    .in_lead   (state_q == LEAD),
    .in_shift  (state_q == SHIFT),
    .sclk      (sclk_int),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge),
    .last_trail(last_trail),
    .done      (done)
  );

  assign accept = bus.tx_valid && (state_q == IDLE);

  // cpha=0 presents bit 0 at accept and advances on trailing edges; the last
  // trailing edge has nothing left to present. cpha=1 presents on leading edges.
  assign advance = mode_q[0] ? lead_edge  : (trail_edge && !last_trail);
  assign sample  = mode_q[0] ? trail_edge : lead_edge;

  always_ff @(posedge pclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = LEAD;
      LEAD:    if (lead_edge) state_d = SHIFT;
      SHIFT:   if (done)      state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (areset) begin
      mode_q     <= MODE0;
      msb_q      <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      mosi_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= done;
      if (accept) begin
        mode_q <= mode_of(bus.cpol, bus.cpha);
        msb_q  <= bus.msb_first;
        if (!bus.cpha) begin
          mosi_q <= head_bit(bus.tx_data, bus.msb_first);
          tx_sr  <= shift_word(bus.tx_data, bus.msb_first);
        end else begin
          tx_sr  <= bus.tx_data;
        end
      end else if (advance) begin
        mosi_q <= head_bit(tx_sr, msb_q);
        tx_sr  <= shift_word(tx_sr, msb_q);
      end
      if (sample)
        rx_sr <= msb_q ? {rx_sr[DATA_WIDTH-2:0], bus.miso0}
                       : {bus.miso0, rx_sr[DATA_WIDTH-1:1]};
      if (done) rx_data_q <= rx_sr;
    end
  end

  assign bus.tx_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.cs       = (state_q == IDLE);
  assign bus.sclk     = sclk_int;
  assign bus.mosi0    = mosi_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
endmodule

// File: doc/spi_master_shifter.md
Name: spi_master_shifter

Overview:
Synthesizable SPI master serial engine. It sits directly upstream of the slave-side monitor/driver BFMs and drives the cs/sclk/mosi0 lines they sample. It accepts one parallel word per transfer through a valid/ready handshake and serializes it on mosi0 in the selected CPOL/CPHA mode and bit order. It deserializes miso0 in the same transfer and returns the received word with a one-cycle valid pulse.

Parameters:
- DATA_WIDTH, 8, bits per transfer; legal range 4..32.
- CLK_DIV, 2, pclk cycles per sclk half-period; legal range >=1.

Ports:
- pclk  input  1  system clock; all logic on rising edge.
- areset  input  1  synchronous, active-high reset.
- tx_valid  input  1  word available on tx_data.
- tx_ready  output  1  engine idle; high = accept.
- tx_data  input  DATA_WIDTH  word to transmit.
- cpol  input  1  clock polarity; sampled at accept.
- cpha  input  1  clock phase; sampled at accept.
- msb_first  input  1  1 = MSB first, 0 = LSB first; sampled at accept.
- rx_valid  output  1  one-cycle pulse; rx_data is valid.
- rx_data  output  DATA_WIDTH  word received on miso0; held until the next pulse.
- busy  output  1  transfer in progress (cs low).
- cs  output  1  chip select, active low.
- sclk  output  1  serial clock.
- mosi0  output  1  master-out data.
- miso0  input  1  master-in data.

Behaviour:
- Single clock pclk; reset is synchronous, active-high on areset.
- Reset values: state IDLE, cs=1, sclk=0, mosi0=0, rx_valid=0, rx_data=0, busy=0. Latched cpol/cpha/msb_first reset to 0. tx_ready=1 in the first cycle after reset deasserts.
- Reset mid-transfer returns to IDLE on the next edge. cs rises immediately. No rx_valid pulse is produced.
- tx_ready = (state==IDLE), decoded from the state register.
- Accept occurs in a cycle where tx_valid && tx_ready (cycle T). tx_data, cpol, cpha and msb_first are latched at T.
- States:
  - IDLE: wait for accept, then go to LEAD.
  - LEAD: lasts CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 2*DATA_WIDTH half-periods of CLK_DIV cycles each, then go to IDLE.
- From T+1: cs=0, busy=1, sclk=latched cpol.
- With cpha=0, mosi0 carries the first bit from T+1.
- A divider counter runs 0..CLK_DIV-1 in LEAD and SHIFT; its wrap is an edge tick.
- An edge counter runs 0..2*DATA_WIDTH-1. Each SHIFT half-period begins with an sclk toggle.
- Odd edges (1st, 3rd, ...) are leading edges (sclk leaves cpol); even edges are trailing.
- cpha=0: sample miso0 on each leading edge; advance mosi0 to the next bit on each trailing edge except the last.
- cpha=1: drive the next mosi0 bit on each leading edge; sample miso0 on each trailing edge.
- Sampling captures miso0 at the pclk edge where sclk toggles.
- Shift direction: msb_first=1 shifts left, tx MSB first, rx enters at LSB. msb_first=0 mirrors this.
- After the last half-period elapses: state IDLE, cs=1, busy=0, rx_valid=1 for one cycle, rx_data updated, tx_ready=1, sclk stays at cpol, mosi0 holds its last bit.
- cs is low for exactly (2*DATA_WIDTH+1)*CLK_DIV cycles; for 8 bits with CLK_DIV=2 that is 34 cycles.
- Back-to-back: tx_valid held high gives an accept in the rx_valid cycle, so cs is high for exactly 1 cycle between words.
- tx_valid and all config inputs are ignored while busy.
- A cpol change takes effect on sclk at T+1, the same cycle cs falls. No sclk edge is counted for that change.

Decomposition:
- Shared package spi_rtl_pkg holds:
  - state enum spi_mst_state_e {IDLE, LEAD, SHIFT};
  - typedef spi_mode_e {MODE0..MODE3} = {cpol,cpha};
  - localparams for DATA_WIDTH bounds.
- One natural sub-module, spi_sclk_gen: divider counter, edge counter, sclk register, and leading/trailing/done strobes. The shift registers and FSM remain in the top module.

Test Plan:
- Mode 0, MSB first, CLK_DIV=2: tx_data=8'hA5, miso0 driven 8'h3C. Expect:
  - mosi0 at leading edges reads 1,0,1,0,0,1,0,1;
  - cs low 34 cycles;
  - rx_valid one pulse with rx_data=8'h3C;
  - sclk ends at 0.
- Mode 3, LSB first: tx_data=8'h81, miso0 8'hF0. Expect:
  - sclk idles 1;
  - mosi0 changes on falling edges, sequence 1,0,0,0,0,0,0,1;
  - rx_data=8'hF0;
  - sclk returns to 1.
- Back-to-back: tx_valid held high with words 8'h11 then 8'h22. Expect two accepts, cs high exactly 1 cycle between transfers, two rx_valid pulses.
- Busy protection: tx_valid toggled with 8'hFF during a transfer of 8'h5A. Expect tx_ready=0 throughout, mosi0 serializes 8'h5A only, exactly one accept.
- Reset mid-transfer: assert areset at edge 7 of 16. Expect next cycle cs=1, sclk=0, busy=0, no rx_valid; a new transfer of 8'hC3 then completes correctly.
- CLK_DIV=1, DATA_WIDTH=16, mode 1: tx 16'hBEEF. Expect cs low 33 cycles and rx equal to the looped-back mosi0 (16'hBEEF).
